// File: rtl/sram_bridge_if.sv
// rtl/sram_bridge_if.sv - core byte bus and asynchronous SRAM pin bundle for sram_bridge
interface sram_bridge_if;
  logic [19:0] cpu_address;
  logic [7:0]  cpu_out;
  logic        cpu_we;
  logic [7:0]  cpu_in;
  logic        cpu_ce;
  logic [18:0] sram_addr;
  logic [15:0] sram_dq_i;
  logic [15:0] sram_dq_o;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic        sram_lb_n;
  logic        sram_ub_n;

  modport master (
    output cpu_address, cpu_out, cpu_we, sram_dq_i,
    input  cpu_in, cpu_ce, sram_addr, sram_dq_o, sram_dq_oe,
    input  sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n
  );

  modport slave (
    input  cpu_address, cpu_out, cpu_we, sram_dq_i,
    output cpu_in, cpu_ce, sram_addr, sram_dq_o, sram_dq_oe,
    output sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n
  );
endinterface

// File: rtl/sram_bridge.sv
// rtl/sram_bridge.sv - core byte bus to 16-bit async SRAM bridge with wait states
// Optional single-word read cache enabled by defining SRAM_BRIDGE_CACHE_EN.
module sram_bridge #(
  parameter int WAIT_STATES = 1
) (
  input  logic          clock,
  input  logic          reset_n,
  sram_bridge_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, RD_SETUP, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, READY
  } state_t;

  localparam logic [3:0] WR_LOAD = 4'(WAIT_STATES);
  localparam logic [3:0] RD_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t      state, state_nxt;
  logic [18:0] lat_addr;
  logic        lat_lane;
  logic        lat_we;
  logic [7:0]  lat_data;
  logic [15:0] word_q;
  logic        tag_valid;
  logic [3:0]  wait_cnt;
  logic        hit;
  logic        start;
  logic        rd_done;
  logic        wr_done;
  logic        in_rd;
  logic        in_wr;
`ifdef SRAM_BRIDGE_CACHE_EN
  logic [18:0] word_tag;
  logic        word_valid;
`endif

  // Writes only ever hit on the exact byte tag so a held write keeps cpu_ce high without repeating.
  always_comb begin
    hit = tag_valid && ({bus.cpu_address, bus.cpu_we} == {lat_addr, lat_lane, lat_we});
`ifdef SRAM_BRIDGE_CACHE_EN
    if (!bus.cpu_we)
      hit = word_valid && (bus.cpu_address[19:1] == word_tag);
`endif
  end

  assign start   = (state == IDLE) || ((state == READY) && !hit);
  assign rd_done = ((state == RD_SETUP) && (WAIT_STATES == 0)) ||
                   ((state == RD_WAIT) && (wait_cnt == 4'd0));
  assign wr_done = (state == WR_HOLD);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, READY: if (start) state_nxt = bus.cpu_we ? WR_SETUP : RD_SETUP;
      RD_SETUP:    state_nxt = (WAIT_STATES == 0) ? READY : RD_WAIT;
      RD_WAIT:     if (wait_cnt == 4'd0) state_nxt = READY;
      WR_SETUP:    state_nxt = WR_PULSE;
      WR_PULSE:    if (wait_cnt == 4'd0) state_nxt = WR_HOLD;
      WR_HOLD:     state_nxt = READY;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      lat_addr  <= '0;
      lat_lane  <= 1'b0;
      lat_we    <= 1'b0;
      lat_data  <= '0;
      word_q    <= '0;
      tag_valid <= 1'b0;
      wait_cnt  <= '0;
`ifdef SRAM_BRIDGE_CACHE_EN
      word_tag   <= '0;
      word_valid <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (start) begin
        lat_addr <= bus.cpu_address[19:1];
        lat_lane <= bus.cpu_address[0];
        lat_we   <= bus.cpu_we;
        lat_data <= bus.cpu_out;
      end
      if ((state_nxt == RD_WAIT) && (state != RD_WAIT))
        wait_cnt <= RD_LOAD;
      else if ((state_nxt == WR_PULSE) && (state != WR_PULSE))
        wait_cnt <= WR_LOAD;
      else if (wait_cnt != 4'd0)
        wait_cnt <= wait_cnt - 4'd1;
      if (rd_done) begin
        word_q    <= bus.sram_dq_i;
        tag_valid <= 1'b1;
`ifdef SRAM_BRIDGE_CACHE_EN
        word_tag   <= lat_addr;
        word_valid <= 1'b1;
`endif
      end
      if (wr_done) begin
        tag_valid <= 1'b1;
`ifdef SRAM_BRIDGE_CACHE_EN
        // Only fold the byte in when it belongs to the cached word; otherwise the cache stays intact.
        if (word_valid && (word_tag == lat_addr)) begin
          if (lat_lane) word_q[15:8] <= lat_data;
          else          word_q[7:0]  <= lat_data;
        end
`else
        if (lat_lane) word_q[15:8] <= lat_data;
        else          word_q[7:0]  <= lat_data;
`endif
      end
    end
  end

  assign in_rd = (state == RD_SETUP) || (state == RD_WAIT);
  assign in_wr = (state == WR_SETUP) || (state == WR_PULSE) || (state == WR_HOLD);

  assign bus.cpu_ce     = (state == READY) && hit;
  assign bus.cpu_in     = bus.cpu_address[0] ? word_q[15:8] : word_q[7:0];
  assign bus.sram_addr  = lat_addr;
  assign bus.sram_dq_o  = {lat_data, lat_data};
  assign bus.sram_dq_oe = in_wr;
  assign bus.sram_we_n  = !(state == WR_PULSE);
  assign bus.sram_oe_n  = !in_rd;
  assign bus.sram_lb_n  = !((in_rd || in_wr) && !lat_lane);
  assign bus.sram_ub_n  = !((in_rd || in_wr) && lat_lane);

endmodule

// File: tb/tb_sram_bridge.sv
// tb/tb_sram_bridge.sv - directed bench for sram_bridge at WAIT_STATES 0, 1 and 15
module tb_sram_bridge;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  sram_bridge_if b0 ();
  sram_bridge_if b1 ();
  sram_bridge_if b15 ();

  sram_bridge #(.WAIT_STATES(0))  dut0  (.clock(clock), .reset_n(reset_n), .bus(b0.slave));
  sram_bridge #(.WAIT_STATES(1))  dut1  (.clock(clock), .reset_n(reset_n), .bus(b1.slave));
  sram_bridge #(.WAIT_STATES(15)) dut15 (.clock(clock), .reset_n(reset_n), .bus(b15.slave));

  logic [15:0] mem0  [16];
  logic [15:0] mem1  [16];
  logic [15:0] mem15 [16];

  assign b0.sram_dq_i  = mem0[b0.sram_addr[3:0]];
  assign b1.sram_dq_i  = mem1[b1.sram_addr[3:0]];
  assign b15.sram_dq_i = mem15[b15.sram_addr[3:0]];

  int st0, st1, st15, oe0, oe1, oe15, we0, we1, we15;
  logic [18:0] cap_addr;
  logic [15:0] cap_dq;
  logic cap_lb, cap_ub, cap_rlb, cap_rub;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [19:0] a, input logic w, input logic [7:0] d);
    b0.cpu_address = a;  b0.cpu_we = w;  b0.cpu_out = d;
    b1.cpu_address = a;  b1.cpu_we = w;  b1.cpu_out = d;
    b15.cpu_address = a; b15.cpu_we = w; b15.cpu_out = d;
  endtask

  // Samples on falling edges until every bridge raises cpu_ce, acting as the SRAM array for writes.
  task automatic measure();
    bit d0 = 0, d1 = 0, d15 = 0;
    st0 = 0; st1 = 0; st15 = 0; oe0 = 0; oe1 = 0; oe15 = 0; we0 = 0; we1 = 0; we15 = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (!b1.sram_we_n && b1.sram_dq_oe) begin
        cap_addr = b1.sram_addr; cap_dq = b1.sram_dq_o;
        cap_lb = b1.sram_lb_n;   cap_ub = b1.sram_ub_n;
        if (!b1.sram_lb_n) mem1[b1.sram_addr[3:0]][7:0]  = b1.sram_dq_o[7:0];
        if (!b1.sram_ub_n) mem1[b1.sram_addr[3:0]][15:8] = b1.sram_dq_o[15:8];
      end
      if (!b0.sram_we_n && b0.sram_dq_oe) begin
        if (!b0.sram_lb_n) mem0[b0.sram_addr[3:0]][7:0]  = b0.sram_dq_o[7:0];
        if (!b0.sram_ub_n) mem0[b0.sram_addr[3:0]][15:8] = b0.sram_dq_o[15:8];
      end
      if (!b15.sram_we_n && b15.sram_dq_oe) begin
        if (!b15.sram_lb_n) mem15[b15.sram_addr[3:0]][7:0]  = b15.sram_dq_o[7:0];
        if (!b15.sram_ub_n) mem15[b15.sram_addr[3:0]][15:8] = b15.sram_dq_o[15:8];
      end
      if (!b1.sram_oe_n) begin cap_rlb = b1.sram_lb_n; cap_rub = b1.sram_ub_n; end
      if (!d0) begin
        if (b0.cpu_ce) d0 = 1; else st0++;
        if (!b0.sram_oe_n) oe0++;
        if (!b0.sram_we_n) we0++;
      end
      if (!d1) begin
        if (b1.cpu_ce) d1 = 1; else st1++;
        if (!b1.sram_oe_n) oe1++;
        if (!b1.sram_we_n) we1++;
      end
      if (!d15) begin
        if (b15.cpu_ce) d15 = 1; else st15++;
        if (!b15.sram_oe_n) oe15++;
        if (!b15.sram_we_n) we15++;
      end
      if (d0 && d1 && d15) break;
    end
  endtask

  task automatic access(input logic [19:0] a, input logic w, input logic [7:0] d);
    @(posedge clock); #1;
    drive(a, w, d);
    measure();
  endtask

  initial begin
    int held_we;
    for (int i = 0; i < 16; i++) begin
      mem0[i] = 16'h0000; mem1[i] = 16'h0000; mem15[i] = 16'h0000;
    end
    mem0[0] = 16'h5512; mem1[0] = 16'h5512; mem15[0] = 16'h5512;
    mem0[1] = 16'h9A34; mem1[1] = 16'h9A34; mem15[1] = 16'h9A34;
    drive(20'h00001, 1'b0, 8'h00);

    #12;
    chk("reset_ce",    {31'd0, b1.cpu_ce},     32'd0);
    chk("reset_cpu_in", {24'd0, b1.cpu_in},    32'h00);
    chk("reset_we_n",  {31'd0, b1.sram_we_n},  32'd1);
    chk("reset_oe_n",  {31'd0, b1.sram_oe_n},  32'd1);
    chk("reset_lanes", {30'd0, b1.sram_lb_n, b1.sram_ub_n}, 32'd3);
    chk("reset_dq_oe", {31'd0, b1.sram_dq_oe}, 32'd0);
    chk("reset_addr",  {13'd0, b1.sram_addr},  32'd0);

    // Read 0x00001 straight out of reset; the release cycle is the mismatch cycle.
    @(posedge clock); #1;
    reset_n = 1'b1;
    measure();
    chk("rd1_stall",   st1, 3);
    chk("rd1_oe",      oe1, 2);
    chk("rd1_data",    {24'd0, b1.cpu_in}, 32'h55);
    chk("rd1_lb_n",    {31'd0, cap_rlb}, 32'd1);
    chk("rd1_ub_n",    {31'd0, cap_rub}, 32'd0);
    chk("rd0_stall",   st0, 2);
    chk("rd0_oe",      oe0, 1);
    chk("rd15_stall",  st15, 17);
    chk("rd15_data",   {24'd0, b15.cpu_in}, 32'h55);

    access(20'hFFFF0, 1'b1, 8'hEA);
    chk("wr1_stall",   st1, 5);
    chk("wr1_we",      we1, 2);
    chk("wr1_addr",    {13'd0, cap_addr}, 32'h7FFF8);
    chk("wr1_dq",      {16'd0, cap_dq}, 32'hEAEA);
    chk("wr1_lanes",   {30'd0, cap_lb, cap_ub}, 32'd1);
    chk("wr0_stall",   st0, 4);
    chk("wr15_we",     we15, 16);
    chk("wr15_stall",  st15, 19);

    held_we = 0;
    repeat (3) begin
      @(negedge clock);
      if (!b1.sram_we_n) held_we++;
    end
    chk("held_wr_we",  held_we, 0);
    chk("held_wr_ce",  {31'd0, b1.cpu_ce}, 32'd1);

    access(20'hFFFF0, 1'b0, 8'h00);
    chk("rdback_stall", st1, 3);
    chk("rdback_data", {24'd0, b1.cpu_in}, 32'hEA);

    // Address moves to 0x00002 while the read of 0x00000 is in RD_WAIT.
    @(posedge clock); #1;
    drive(20'h00000, 1'b0, 8'h00);
    @(posedge clock); #1;
    @(posedge clock); #1;
    drive(20'h00002, 1'b0, 8'h00);
    measure();
    chk("chg_stall",   st1, 4);
    chk("chg_oe",      oe1, 3);
    chk("chg_data",    {24'd0, b1.cpu_in}, 32'h34);

    access(20'h00000, 1'b0, 8'h00);
    chk("rd0x0_stall", st1, 3);
    chk("rd0x0_data",  {24'd0, b1.cpu_in}, 32'h12);
    access(20'h00001, 1'b0, 8'h00);
`ifdef SRAM_BRIDGE_CACHE_EN
    chk("cache_hit_stall", st1, 0);
    chk("cache_hit_oe",    oe1, 0);
    chk("cache_hit_data",  {24'd0, b1.cpu_in}, 32'h55);
    access(20'h00001, 1'b1, 8'h77);
    chk("cache_wr_stall",  st1, 5);
    access(20'h00001, 1'b0, 8'h00);
    chk("cache_rb_stall",  st1, 0);
    chk("cache_rb_data",   {24'd0, b1.cpu_in}, 32'h77);
    chk("cache_wr_thru",   {16'd0, mem1[0]}, 32'h7712);
`else
    chk("nocache_stall",   st1, 3);
    chk("nocache_oe",      oe1, 2);
    chk("nocache_data",    {24'd0, b1.cpu_in}, 32'h55);
`endif

    // Reset lands between edges while the write strobe is low.
    @(posedge clock); #1;
    drive(20'h00004, 1'b1, 8'h11);
    @(posedge clock); #1;
    @(posedge clock); #3;
    chk("midwr_we_low", {31'd0, b1.sram_we_n}, 32'd0);
    reset_n = 1'b0;
    #1;
    chk("midwr_we_n",   {31'd0, b1.sram_we_n},  32'd1);
    chk("midwr_dq_oe",  {31'd0, b1.sram_dq_oe}, 32'd0);
    chk("midwr_oe_n",   {31'd0, b1.sram_oe_n},  32'd1);
    chk("midwr_ce",     {31'd0, b1.cpu_ce},     32'd0);
    chk("midwr_cpu_in", {24'd0, b1.cpu_in},     32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
